// File: rtl/gc_pkg.sv
// Shared definitions for the GameCube-side Joybus receive path.
package gc_pkg;

  // Receive state of the bit decoder.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_ERR
  } gc_state_t;

  // Data bits in one controller response, excluding the stop bit.
  localparam int GC_FRAME_BITS = 64;

  // System clock the default timing constants are derived from.
  localparam int CLK_HZ = 50_000_000;

  // Longest low phase still read as a '1' (2 us).
  localparam int GC_SHORT_MAX = CLK_HZ / 500_000;

  // Low phase length treated as a stuck line (5 us).
  localparam int GC_LOW_MAX = CLK_HZ / 200_000;

  // High time after a bit that closes the frame (5 us).
  localparam int GC_IDLE_CYCLES = CLK_HZ / 200_000;

  function automatic int gc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gc_pulse_timer.sv
// Edge detector plus saturating width counter for a single-wire serial line.
// 'reached' is high in the cycle whose count update brings the counter to
// 'limit', so a phase of exactly 'limit' samples trips it.
module gc_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         level,
  input  logic         restart,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         fall,
  output logic         rise,
  output logic [W-1:0] count,
  output logic         reached
);

  logic prev;

  assign fall    = prev & ~level;
  assign rise    = ~prev & level;
  assign reached = ({1'b0, count} + 1'b1) >= {1'b0, limit};

  // Previous line value; idle line is high, so it resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  // Width counter: clear to 0, restart at 1 (the edge sample itself), else saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (restart) begin
      count <= {{(W-1){1'b0}}, 1'b1};
    end else if (count != {W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gc_bit_decoder.sv
// Joybus receive decoder: classifies each bit by its low-phase width, shifts
// the bits into a response register and closes the frame on an idle-high timeout.
module gc_bit_decoder import gc_pkg::*; #(
  parameter int NBITS       = GC_FRAME_BITS,
  parameter int SHORT_MAX   = GC_SHORT_MAX,
  parameter int LOW_MAX     = GC_LOW_MAX,
  parameter int IDLE_CYCLES = GC_IDLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             debounced,
  input  logic             enable,
  output logic [NBITS-1:0] data,
  output logic             valid,
  output logic             error,
  output logic             busy
);

  localparam int CW = $clog2(gc_max(LOW_MAX, IDLE_CYCLES) + 1);
  localparam int BW = $clog2(NBITS + 2);

  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_MAX);
  localparam logic [CW-1:0] LOW_C   = CW'(LOW_MAX);
  localparam logic [CW-1:0] IDLE_C  = CW'(IDLE_CYCLES);
  localparam logic [BW-1:0] FULL_C  = BW'(NBITS + 1);

  gc_state_t        state, state_next;
  logic [NBITS:0]   sr, sr_next;
  logic [BW-1:0]    bitcnt, bitcnt_next;
  logic [NBITS-1:0] data_next;
  logic             valid_next, error_next;
  logic             restart, clear, bit_val;
  logic [CW-1:0]    limit, count;
  logic             fall, rise, reached;

  gc_pulse_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (debounced),
    .restart (restart),
    .clear   (clear),
    .limit   (limit),
    .fall    (fall),
    .rise    (rise),
    .count   (count),
    .reached (reached)
  );

  assign busy = (state != ST_IDLE);

  // State, shift register, bit count and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sr     <= '0;
      bitcnt <= '0;
      data   <= '0;
      valid  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_next;
      sr     <= sr_next;
      bitcnt <= bitcnt_next;
      data   <= data_next;
      valid  <= valid_next;
      error  <= error_next;
    end
  end

  // Next-state logic; enable (adapter transmitting) overrides everything and aborts quietly.
  always_comb begin
    state_next  = state;
    sr_next     = sr;
    bitcnt_next = bitcnt;
    data_next   = data;
    valid_next  = 1'b0;
    error_next  = 1'b0;
    restart     = 1'b0;
    clear       = 1'b0;
    limit       = (state == ST_LOW) ? LOW_C : IDLE_C;
    bit_val     = (count <= SHORT_C);
    if (enable) begin
      state_next  = ST_IDLE;
      clear       = 1'b1;
      sr_next     = '0;
      bitcnt_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clear   = ~fall;
          restart = fall;
          if (fall) begin
            state_next  = ST_LOW;
            sr_next     = '0;
            bitcnt_next = '0;
          end
        end
        ST_LOW: begin
          if (rise) begin
            restart = 1'b1;
            if (bitcnt == FULL_C) begin
              error_next = 1'b1;
              state_next = ST_ERR;
            end else begin
              sr_next     = {sr[NBITS-1:0], bit_val};
              bitcnt_next = bitcnt + 1'b1;
              state_next  = ST_HIGH;
            end
          end else if (reached) begin
            clear      = 1'b1;
            error_next = 1'b1;
            state_next = ST_ERR;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            restart    = 1'b1;
            state_next = ST_LOW;
          end else if (reached) begin
            clear      = 1'b1;
            state_next = ST_IDLE;
            if (bitcnt == FULL_C && sr[0]) begin
              data_next  = sr[NBITS:1];
              valid_next = 1'b1;
            end else begin
              error_next = 1'b1;
            end
          end
        end
        ST_ERR: begin
          if (!debounced) begin
            clear = 1'b1;
          end else if (reached) begin
            clear      = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule
